// File: rtl/ctr_out_buf.sv
// ctr_out_buf
//   Read-side consumer of the CTR-DRBG post-processor output. Each 128-bit
//   block offered on ctr_dataout/ctr_dataout_vld is split into four 32-bit
//   words, pushed into a word FIFO and acknowledged with a one-cycle
//   rngcore_rddone pulse. The bus side drains one word per rd_req. Withholding
//   rddone while the FIFO lacks room for a whole block paces the DRBG.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   rngcore_en         core enable; low clears the buffer and holds it idle
//   flush              synchronous clear
//   ctr_dataout[127:0] DRBG output block, valid while ctr_dataout_vld is high
//   rngcore_rddone     registered one-cycle acknowledge of a captured block
//   rd_req             bus read request, one word per cycle
//   rd_data[31:0]      read word, qualified by rd_valid (1-cycle latency)
//   fifo_level         stored words, 0..DEPTH
//   fifo_empty/full    decoded from fifo_level
//   rd_underflow       sticky, set by a read request against an empty FIFO
module ctr_out_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rngcore_en,
    input  logic          flush,
    input  logic [127:0]  ctr_dataout,
    input  logic          ctr_dataout_vld,
    output logic          rngcore_rddone,
    input  logic          rd_req,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    output logic [AW:0]   fifo_level,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic          rd_underflow
);

    localparam int LVL_W = AW + 1;
    // A block fits only if at least four word slots are free.
    localparam logic [AW:0] PUSH_LIM = LVL_W'(DEPTH - 4);
    localparam logic [AW:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic {IDLE, ACK} state_e;

    state_e        state_q, state_d;
    logic          rddone_q, rddone_d;
    logic          rd_valid_q, rd_valid_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_underflow_q, rd_underflow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [31:0]   mem_q [DEPTH];

    logic clr, push, pop, empty;

    assign empty = (level_q == '0);

    always_comb begin
        clr  = flush | ~rngcore_en;
        // Capture only from IDLE: vld is still high during the rddone cycle,
        // so sampling it in ACK would take the same block twice. The space
        // check uses the level before this edge's pop.
        push = ~clr & (state_q == IDLE) & ctr_dataout_vld & (level_q <= PUSH_LIM);
        pop  = ~clr & rd_req & ~empty;

        state_d        = push ? ACK : IDLE;
        rddone_d       = push;
        rd_valid_d     = pop;
        rd_data_d      = pop ? mem_q[rd_ptr_q] : rd_data_q;
        rd_underflow_d = rd_underflow_q | (rd_req & empty);
        wr_ptr_d       = push ? wr_ptr_q + AW'(4) : wr_ptr_q;
        rd_ptr_d       = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d        = level_q + (push ? LVL_W'(4) : LVL_W'(0))
                                 - (pop  ? LVL_W'(1) : LVL_W'(0));

        if (clr) begin
            rd_underflow_d = 1'b0;
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            level_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            rddone_q       <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            rd_underflow_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
        end else begin
            state_q        <= state_d;
            rddone_q       <= rddone_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            rd_underflow_q <= rd_underflow_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
        end
    end

    // Storage needs no reset: nothing is read before it has been written.
    // A push never overlaps the slot being popped because a push requires
    // at most DEPTH-4 words stored.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[wr_ptr_q + AW'(k)] <= ctr_dataout[32*k +: 32];
            end
        end
    end

    assign rngcore_rddone = rddone_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign rd_underflow   = rd_underflow_q;
    assign fifo_level     = level_q;
    assign fifo_empty     = empty;
    assign fifo_full      = (level_q == FULL_LVL);

endmodule

// File: tb/tb_ctr_out_buf.sv
// Testbench for ctr_out_buf: a cycle table covering the single-block,
// simultaneous push/pop, underflow and flush-in-ACK cases, followed by
// hand-written sequences for backpressure, wrap-around streaming, disable
// and asynchronous reset.
module tb_ctr_out_buf;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rngcore_en = 1'b0;
    logic          flush = 1'b0;
    logic [127:0]  ctr_dataout = '0;
    logic          ctr_dataout_vld = 1'b0;
    logic          rngcore_rddone;
    logic          rd_req = 1'b0;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic [AW:0]   fifo_level;
    logic          fifo_empty;
    logic          fifo_full;
    logic          rd_underflow;

    int checks = 0;
    int errors = 0;

    ctr_out_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .rngcore_en(rngcore_en), .flush(flush),
        .ctr_dataout(ctr_dataout), .ctr_dataout_vld(ctr_dataout_vld),
        .rngcore_rddone(rngcore_rddone), .rd_req(rd_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .fifo_level(fifo_level), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .rd_underflow(rd_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en, fl, vld;
        logic [127:0] din;
        logic         rd;
        logic         e_done, e_val;
        logic [31:0]  e_data;
        logic         chk_data;
        logic [4:0]   e_lvl;
        logic         e_uf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Block n carries words 4n, 4n+1, 4n+2, 4n+3 (word0 in the low bits).
    function automatic logic [127:0] blk(input int n);
        return {32'(4*n+3), 32'(4*n+2), 32'(4*n+1), 32'(4*n)};
    endfunction

    task automatic push_blk(input logic [127:0] d, input logic [31:0] exp_lvl, input string nm);
        ctr_dataout_vld = 1'b1;
        ctr_dataout = d;
        step();
        chk({nm, "_done"}, 32'(rngcore_rddone), 32'd1);
        chk({nm, "_lvl"}, 32'(fifo_level), exp_lvl);
        step();  // ACK cycle, vld still high
        chk({nm, "_ack"}, 32'(rngcore_rddone), 32'd0);
        ctr_dataout_vld = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    localparam logic [127:0] BA = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] BB = 128'h88888888_77777777_66666666_55555555;
    localparam logic [127:0] BC = 128'hcccccccc_bbbbbbbb_aaaaaaaa_99999999;
    localparam logic [127:0] BD = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] BE = 128'hfeedf00d_cafef00d_0badc0de_deadbeef;

    vec_t vt [18];

    initial begin
        // en fl vld din rd | done val data chkdata lvl uf
        vt[0]  = '{1,0,1,BA,0, 1,0,32'h0,       1, 4,0};
        vt[1]  = '{1,0,1,BA,0, 0,0,32'h0,       1, 4,0};
        vt[2]  = '{1,0,0,BA,1, 0,1,32'h11111111,1, 3,0};
        vt[3]  = '{1,0,0,BA,1, 0,1,32'h22222222,1, 2,0};
        vt[4]  = '{1,0,0,BA,1, 0,1,32'h33333333,1, 1,0};
        vt[5]  = '{1,0,0,BA,1, 0,1,32'h44444444,1, 0,0};
        vt[6]  = '{1,0,0,BA,1, 0,0,32'h44444444,1, 0,1};  // underflow
        vt[7]  = '{1,0,1,BB,0, 1,0,32'h44444444,1, 4,1};
        vt[8]  = '{1,0,1,BB,0, 0,0,32'h44444444,1, 4,1};
        vt[9]  = '{1,0,1,BC,1, 1,1,32'h55555555,1, 7,1};  // push + pop
        vt[10] = '{1,0,1,BC,0, 0,0,32'h55555555,1, 7,1};
        vt[11] = '{1,0,0,BC,1, 0,1,32'h66666666,1, 6,1};
        vt[12] = '{1,0,0,BC,1, 0,1,32'h77777777,1, 5,1};
        vt[13] = '{1,0,0,BC,1, 0,1,32'h88888888,1, 4,1};
        vt[14] = '{1,0,1,BD,0, 1,0,32'h88888888,1, 8,1};  // now in ACK
        vt[15] = '{1,1,1,BD,0, 0,0,32'h0,       0, 0,0};  // flush in ACK
        vt[16] = '{1,0,1,BE,0, 1,0,32'h0,       0, 4,0};  // capture: back in IDLE
        vt[17] = '{1,0,0,BE,1, 0,1,32'hdeadbeef,1, 3,0};  // old data gone

        // Reset state
        #3;
        chk("rst_done", 32'(rngcore_rddone), 0);
        chk("rst_val", 32'(rd_valid), 0);
        chk("rst_data", rd_data, 0);
        chk("rst_uf", 32'(rd_underflow), 0);
        chk("rst_lvl", 32'(fifo_level), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        #9 rstn = 1'b1;

        // Table: inputs for one cycle, outputs sampled after the edge
        foreach (vt[i]) begin
            rngcore_en = vt[i].en;
            flush = vt[i].fl;
            ctr_dataout_vld = vt[i].vld;
            ctr_dataout = vt[i].din;
            rd_req = vt[i].rd;
            step();
            chk($sformatf("vec%0d_done", i), 32'(rngcore_rddone), 32'(vt[i].e_done));
            chk($sformatf("vec%0d_val", i), 32'(rd_valid), 32'(vt[i].e_val));
            if (vt[i].chk_data)
                chk($sformatf("vec%0d_data", i), rd_data, vt[i].e_data);
            chk($sformatf("vec%0d_lvl", i), 32'(fifo_level), 32'(vt[i].e_lvl));
            chk($sformatf("vec%0d_empty", i), 32'(fifo_empty), 32'(vt[i].e_lvl == 0));
            chk($sformatf("vec%0d_uf", i), 32'(rd_underflow), 32'(vt[i].e_uf));
        end
        flush = 1'b0; rd_req = 1'b0; ctr_dataout_vld = 1'b0;

        // Backpressure
        do_flush();
        push_blk(blk(0), 4, "bp0");
        push_blk(blk(1), 8, "bp1");
        push_blk(blk(2), 12, "bp2");
        push_blk(blk(3), 16, "bp3");
        chk("bp_full", 32'(fifo_full), 1);
        begin
            int pulses = 0;
            ctr_dataout_vld = 1'b1;
            ctr_dataout = blk(4);
            for (int c = 0; c < 20; c++) begin
                step();
                if (rngcore_rddone) pulses++;
            end
            chk("bp_stall20", 32'(pulses), 0);
            chk("bp_stall_lvl", 32'(fifo_level), 16);
        end
        for (int r = 0; r < 4; r++) begin
            rd_req = 1'b1;
            step();
            chk($sformatf("bp_rd%0d_data", r), rd_data, 32'(r));
            chk($sformatf("bp_rd%0d_val", r), 32'(rd_valid), 1);
            chk($sformatf("bp_rd%0d_lvl", r), 32'(fifo_level), 32'(15 - r));
            chk($sformatf("bp_rd%0d_done", r), 32'(rngcore_rddone), 0);
        end
        rd_req = 1'b0;
        step();
        chk("bp_cap_done", 32'(rngcore_rddone), 1);
        chk("bp_cap_lvl", 32'(fifo_level), 16);
        step();
        chk("bp_cap_ack", 32'(rngcore_rddone), 0);
        ctr_dataout_vld = 1'b0;

        // Wrap-around streaming with continuous reads
        do_flush();
        begin
            int blk_i = 0, pulses = 0, nread = 0;
            logic adv = 1'b0;
            logic [31:0] expq[$];
            ctr_dataout = blk(16);
            ctr_dataout_vld = 1'b1;
            rd_req = 1'b1;
            for (int cyc = 0; cyc < 400 && !(pulses == 10 && nread == 40); cyc++) begin
                step();
                if (rd_valid) begin
                    nread++;
                    if (expq.size() == 0) chk("wrap_extra_word", rd_data, 32'hffffffff);
                    else chk($sformatf("wrap_word%0d", nread - 1), rd_data, expq.pop_front());
                end
                if (adv) begin
                    adv = 1'b0;
                    blk_i++;
                    if (blk_i < 10) ctr_dataout = blk(16 + blk_i);
                    else ctr_dataout_vld = 1'b0;
                end
                if (rngcore_rddone) begin
                    pulses++;
                    for (int k = 0; k < 4; k++) expq.push_back(32'(4*(16 + blk_i) + k));
                    adv = 1'b1;
                end
            end
            rd_req = 1'b0;
            ctr_dataout_vld = 1'b0;
            chk("wrap_pulses", 32'(pulses), 10);
            chk("wrap_nread", 32'(nread), 40);
        end

        // Disable with level 4 and vld high
        do_flush();
        push_blk(blk(40), 4, "dis_pre");
        rngcore_en = 1'b0;
        ctr_dataout_vld = 1'b1;
        ctr_dataout = blk(41);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("dis%0d_lvl", c), 32'(fifo_level), 0);
            chk($sformatf("dis%0d_done", c), 32'(rngcore_rddone), 0);
        end
        rngcore_en = 1'b1;
        step();
        chk("reen_done", 32'(rngcore_rddone), 1);
        chk("reen_lvl", 32'(fifo_level), 4);
        step();
        chk("reen_ack", 32'(rngcore_rddone), 0);
        ctr_dataout_vld = 1'b0;
        rd_req = 1'b1;
        step();
        chk("reen_data", rd_data, 32'(4*41));
        chk("reen_val", 32'(rd_valid), 1);
        rd_req = 1'b0;

        // Asynchronous reset mid-operation
        ctr_dataout_vld = 1'b1;
        ctr_dataout = blk(50);
        step();
        chk("arst_pre_done", 32'(rngcore_rddone), 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_lvl", 32'(fifo_level), 0);
        chk("arst_done", 32'(rngcore_rddone), 0);
        chk("arst_empty", 32'(fifo_empty), 1);
        ctr_dataout_vld = 1'b0;
        #3 rstn = 1'b1;
        step();
        chk("arst_post_lvl", 32'(fifo_level), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctr_out_buf.md
Name: ctr_out_buf

Overview:
- Read-side consumer of the CTR-DRBG post-processor output.
- Takes each 128-bit block presented on ctr_dataout/ctr_dataout_vld and acknowledges it with a one-cycle rngcore_rddone pulse.
- Splits the block into four 32-bit words and stores them in a word FIFO, which the register/bus side drains one word per request.
- Provides the backpressure that paces the DRBG generate loop.

Parameters:
- DEPTH, 16, FIFO depth in 32-bit words; power of 2, >= 8.
- AW, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rngcore_en  in  1  RNG core enable; low = flush and hold idle
- flush  in  1  synchronous clear (driven by trng_drng_sel_chg)
- ctr_dataout  in  128  DRBG output block
- ctr_dataout_vld  in  1  block valid; level, cleared by producer the cycle after it samples rngcore_rddone
- rngcore_rddone  out  1  registered one-cycle acknowledge: block consumed
- rd_req  in  1  bus read request, one word per cycle
- rd_data  out  32  read word
- rd_valid  out  1  registered; rd_data valid this cycle
- fifo_level  out  AW+1  words currently stored, 0..DEPTH
- fifo_empty  out  1  fifo_level==0
- fifo_full  out  1  fifo_level==DEPTH
- rd_underflow  out  1  sticky: rd_req seen while empty

Behaviour:
- Reset values:
  - rngcore_rddone=0, rd_valid=0, rd_data=0, rd_underflow=0.
  - Pointers=0, fifo_level=0, fifo_empty=1, fifo_full=0.
  - State = IDLE.
- Capture FSM states: IDLE, ACK.
  - IDLE -> ACK when rngcore_en & ~flush & ctr_dataout_vld & (fifo_level <= DEPTH-4).
    - On that edge, write words at wr_ptr..wr_ptr+3 (mod DEPTH): word0=ctr_dataout[31:0], word1=[63:32], word2=[95:64], word3=[127:96].
    - wr_ptr += 4.
    - rngcore_rddone=1 in the following cycle only.
  - ACK -> IDLE unconditionally. No capture is allowed in ACK, because ctr_dataout_vld is still high during the rddone cycle; this prevents double capture.
  - If vld is high but space < 4: stay in IDLE, no rddone, producer stalls. Retry every cycle.
- Read path:
  - rd_req & ~fifo_empty: next cycle rd_data = mem[rd_ptr], rd_valid=1, and rd_ptr += 1.
  - rd_req & fifo_empty: next cycle rd_valid=0, rd_data holds its previous value, rd_underflow=1.
  - Read latency is 1 cycle. Back-to-back reads are allowed every cycle.
- Level arithmetic:
  - Same edge: fifo_level_next = fifo_level + (push?4:0) - (pop?1:0).
  - The push/space decision uses the pre-pop level.
  - Pointers wrap mod DEPTH via natural AW-bit overflow.
- Simultaneous push and pop on the same edge is legal. A pop of the oldest word is unaffected by the write, since the FIFO never holds DEPTH-3 or more words when pushing.
- Flush (flush=1 or rngcore_en=0), priority over push and pop:
  - Clear pointers, level and rd_underflow; set state IDLE.
  - rngcore_rddone=0 next cycle, even if the clear lands in ACK.
  - rd_valid=0 next cycle.
  - Stored data is discarded; memory contents need not be cleared.
- Async reset mid-operation returns everything to reset values immediately.
- fifo_empty and fifo_full are combinational from fifo_level.
- Memory is flops, with four write ports (one per word) and one read port.

Test Plan:
1. Single block: reset, rngcore_en=1, ctr_dataout=128'h44444444_33333333_22222222_11111111, vld=1 until one cycle after rddone, then four rd_req cycles.
   - Exactly one rddone pulse, 1 cycle after capture.
   - fifo_level goes 0->4->0.
   - rd_data reads 11111111, 22222222, 33333333, 44444444, each with rd_valid.
2. Backpressure (DEPTH=16): push 3 blocks (level 12), then vld=1 with a 4th block and no reads.
   - Capture occurs and level=16, fifo_full=1.
   - A 5th vld block sees no rddone for 20 cycles.
   - One rd_req: level 15, still no capture.
   - Four reads in total: level 12, then capture, rddone pulse, level 16.
3. Simultaneous push/pop: level=4, rd_req on the same edge as capture.
   - Level becomes 7; the word read is the oldest stored word.
4. Wrap-around: stream 10 blocks while reading continuously.
   - All 40 words come out in order across pointer wrap.
   - No lost or duplicate rddone pulses: exactly 10.
5. Underflow/flush: rd_req with empty FIFO.
   - rd_valid=0 and rd_underflow=1.
   - Then flush while in ACK with level 8: next cycle level=0, rddone=0, rd_underflow=0, state IDLE.
6. Disable: drop rngcore_en with level 4 and vld high.
   - Level cleared to 0, no capture, no rddone while disabled.
   - Re-enable: capture resumes with a single rddone pulse.
